wb_mux_n: RTL

Parametrised Wishbone classic 1-master-to-N-slave interconnect. Successor to the fixed 4-port peripheral mux in the digital top.
- Adds registered response, unmapped-address error and cycle-abort handling.
- Optionally adds a bus-timeout watchdog.
- Sits between the Caravel-facing Wishbone slave port and the peripheral slaves (GPIO, UART, ring controllers, future blocks).

---
 rtl/wb_mux_n_pkg.sv | 36 +++
 rtl/wb_mux_n_addr_decode.sv | 26 ++
 rtl/wb_mux_n.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/wb_mux_n_pkg.sv
// Shared types and project address map for the Wishbone 1:N interconnect.
// Pure declarations: no timing, no flow control.
package wb_mux_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    RESP_ACK = 2'd0,
    RESP_ERR = 2'd1,
    RESP_RTY = 2'd2
  } resp_t;

  localparam logic [31:0] GPIO0_BASE  = 32'h3080_0000;
  localparam logic [31:0] PWM0_BASE   = 32'h3081_0000;
  localparam logic [31:0] UART0_BASE  = 32'h3082_0000;
  localparam logic [31:0] RING0_BASE  = 32'h3083_0000;
  localparam logic [31:0] RING1_BASE  = 32'h3084_0000;
  localparam logic [31:0] PERIPH_MASK = 32'hffff_0000;

  localparam int TMO_W = 16;

  // Several slave response lines may fire together; collapse to a single code.
  function automatic resp_t resp_prio(input logic ack, input logic err, input logic rty);
    resp_t r;
    if (err)      r = RESP_ERR;
    else if (rty) r = RESP_RTY;
    else          r = RESP_ACK;
    if (!ack && !err && !rty) r = RESP_ACK;
    return r;
  endfunction

endpackage

// File: rtl/wb_mux_n_addr_decode.sv
// Combinational base/mask address decoder, lowest index wins on overlap.
// Zero latency; no flow control.
module wb_addr_decode
  import wb_mux_pkg::*;
#(
  parameter int                        NUM_SLAVES = 4,
  parameter logic [NUM_SLAVES*32-1:0]  SLAVE_ADDR = '0,
  parameter logic [NUM_SLAVES*32-1:0]  SLAVE_MASK = '0
) (
  input  logic [31:0]           i_adr,
  output logic [NUM_SLAVES-1:0] o_sel,
  output logic                  o_hit
);

  always_comb begin
    o_sel = '0;
    o_hit = 1'b0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (!o_hit && ((i_adr & SLAVE_MASK[32*i +: 32]) == SLAVE_ADDR[32*i +: 32])) begin
        o_sel[i] = 1'b1;
        o_hit    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_mux_n.sv
// Wishbone classic 1:N interconnect; master response 1 cycle after slave response, 3-cycle minimum.
// Slave stalls hold ACTIVE (bounded by a watchdog when WB_MUX_TIMEOUT_EN is defined); cyc drop aborts.
module wb_mux_n
  import wb_mux_pkg::*;
#(
  parameter int                        NUM_SLAVES     = 4,
  parameter logic [NUM_SLAVES*32-1:0]  SLAVE_ADDR     = {RING1_BASE, RING0_BASE, UART0_BASE, GPIO0_BASE},
  parameter logic [NUM_SLAVES*32-1:0]  SLAVE_MASK     = {NUM_SLAVES{PERIPH_MASK}},
  parameter int                        TIMEOUT_CYCLES = 255
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_ni,
  input  logic [31:0]              wbm_adr_i,
  input  logic [31:0]              wbm_dat_i,
  input  logic                     wbm_we_i,
  input  logic [3:0]               wbm_sel_i,
  input  logic                     wbm_stb_i,
  input  logic                     wbm_cyc_i,
  output logic [31:0]              wbm_dat_o,
  output logic                     wbm_ack_o,
  output logic                     wbm_err_o,
  output logic                     wbm_rty_o,
  output logic [31:0]              wbs_adr_o,
  output logic [31:0]              wbs_dat_o,
  output logic                     wbs_we_o,
  output logic [3:0]               wbs_sel_o,
  output logic [NUM_SLAVES-1:0]    wbs_cyc_o,
  output logic [NUM_SLAVES-1:0]    wbs_stb_o,
  input  logic [NUM_SLAVES*32-1:0] wbs_dat_i,
  input  logic [NUM_SLAVES-1:0]    wbs_ack_i,
  input  logic [NUM_SLAVES-1:0]    wbs_err_i,
  input  logic [NUM_SLAVES-1:0]    wbs_rty_i,
  output logic                     busy_o
);

  state_t                r_state;
  state_t                w_nxt_state;
  logic [NUM_SLAVES-1:0] r_sel;
  logic [NUM_SLAVES-1:0] w_dec_sel;
  logic                  w_dec_hit;
  logic [31:0]           r_dat;
  logic [31:0]           w_nxt_dat;
  logic                  w_dat_ld;
  resp_t                 w_nxt_resp;
  logic                  r_ack;
  logic                  r_err;
  logic                  r_rty;
  logic                  w_req;
  logic                  w_s_ack;
  logic                  w_s_err;
  logic                  w_s_rty;
  logic                  w_s_any;
  logic [31:0]           w_s_dat;
  logic                  w_tmo;

  wb_addr_decode #(
    .NUM_SLAVES (NUM_SLAVES),
    .SLAVE_ADDR (SLAVE_ADDR),
    .SLAVE_MASK (SLAVE_MASK)
  ) u_dec (
    .i_adr (wbm_adr_i),
    .o_sel (w_dec_sel),
    .o_hit (w_dec_hit)
  );

  assign w_req   = wbm_cyc_i & wbm_stb_i;
  assign w_s_ack = |(wbs_ack_i & r_sel);
  assign w_s_err = |(wbs_err_i & r_sel);
  assign w_s_rty = |(wbs_rty_i & r_sel);
  assign w_s_any = w_s_ack | w_s_err | w_s_rty;

  always_comb begin
    w_s_dat = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      w_s_dat = w_s_dat | (wbs_dat_i[32*i +: 32] & {32{r_sel[i]}});
    end
  end

`ifdef WB_MUX_TIMEOUT_EN
  logic [TMO_W-1:0] r_tmo_cnt;

  // Zero on every cycle outside ACTIVE, so the first ACTIVE cycle always sees 0.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_tmo_cnt <= '0;
    end else if (r_state != ST_ACTIVE) begin
      r_tmo_cnt <= '0;
    end else if (!w_s_any) begin
      r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end
  end

  assign w_tmo = (r_state == ST_ACTIVE) && (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
`else
  logic w_unused_tmo;
  assign w_unused_tmo = (TIMEOUT_CYCLES > 0);
  assign w_tmo        = 1'b0;
`endif

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_resp  = RESP_ACK;
    w_dat_ld    = 1'b0;
    w_nxt_dat   = '0;
    wbs_cyc_o   = '0;
    wbs_stb_o   = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_req) begin
          if (w_dec_hit) begin
            w_nxt_state = ST_ACTIVE;
          end else begin
            w_nxt_state = ST_RESP;
            w_nxt_resp  = RESP_ERR;
            w_dat_ld    = 1'b1;
          end
        end
      end
      ST_ACTIVE: begin
        wbs_cyc_o = r_sel & {NUM_SLAVES{wbm_cyc_i}};
        wbs_stb_o = r_sel & {NUM_SLAVES{wbm_cyc_i & wbm_stb_i}};
        if (!wbm_cyc_i) begin
          w_nxt_state = ST_IDLE;
        end else if (w_s_any) begin
          w_nxt_state = ST_RESP;
          w_nxt_resp  = resp_prio(w_s_ack, w_s_err, w_s_rty);
          w_dat_ld    = 1'b1;
          w_nxt_dat   = w_s_dat;
        end else if (w_tmo) begin
          w_nxt_state = ST_RESP;
          w_nxt_resp  = RESP_ERR;
          w_dat_ld    = 1'b1;
        end
      end
      ST_RESP: begin
        w_nxt_state = ST_IDLE;
      end
      default: begin
        w_nxt_state = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_state <= ST_IDLE;
      r_sel   <= '0;
      r_dat   <= '0;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_rty   <= 1'b0;
    end else begin
      r_state <= w_nxt_state;
      if (r_state == ST_IDLE && w_nxt_state == ST_ACTIVE) begin
        r_sel <= w_dec_sel;
      end else if (w_nxt_state == ST_IDLE) begin
        r_sel <= '0;
      end
      if (w_dat_ld) begin
        r_dat <= w_nxt_dat;
      end
      r_ack <= (w_nxt_state == ST_RESP) && (w_nxt_resp == RESP_ACK);
      r_err <= (w_nxt_state == ST_RESP) && (w_nxt_resp == RESP_ERR);
      r_rty <= (w_nxt_state == ST_RESP) && (w_nxt_resp == RESP_RTY);
    end
  end

  assign wbm_dat_o = r_dat;
  assign wbm_ack_o = r_ack;
  assign wbm_err_o = r_err;
  assign wbm_rty_o = r_rty;
  assign wbs_adr_o = wbm_adr_i;
  assign wbs_dat_o = wbm_dat_i;
  assign wbs_we_o  = wbm_we_i;
  assign wbs_sel_o = wbm_sel_i;
  assign busy_o    = (r_state != ST_IDLE);

endmodule
